mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM stage of the five-stage RV32I pipeline, directly downstream of the EX-stage ALU.
//  - Address: the ALU result. Store data: rs2.
//  - Runs LB/LH/LW/LBU/LHU/SB/SH/SW over a req/ack data-memory bus.
//  - Stalls upstream until the access completes.
//  - Drives the registered MEM/WB outputs. Non-memory instructions pass through in 1 cycle.
// PARAMETERS
//  ACK_TIMEOUT  16  BUS-state cycles without dmem_ack before the access is aborted (>=1)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  ex_valid       in   1   EX/MEM holds a valid instruction
//  ex_alu_result  in   32  ALU result; memory byte address for loads/stores
//  ex_rs2_data    in   32  store data
//  ex_funct3      in   3   access size/sign
//  ex_mem_read    in   1   load
//  ex_mem_write   in   1   store (never both)
//  ex_rd          in   5   destination register
//  ex_reg_write   in   1   instruction writes rd
//  mem_stall      out  1   hold EX/MEM and earlier stages this cycle
//  dmem_req       out  1   bus request, held until ack/abort
//  dmem_we        out  1   1=write
//  dmem_addr      out  32  {addr[31:2],2'b00}
//  dmem_wdata     out  32  store data replicated into lanes
//  dmem_wstrb     out  4   byte enables (0 on reads)
//  dmem_ack       in   1   1-cycle completion; rdata valid same cycle
//  dmem_rdata     in   32  read word
//  wb_valid       out  1   MEM/WB valid
//  wb_rd          out  5   MEM/WB rd
//  wb_reg_write   out  1   MEM/WB write enable
//  wb_data        out  32  load data, or ALU result for non-mem ops
//  mem_err        out  1   1-cycle pulse together with wb_valid: timeout (or misalign)
// BEHAVIOUR
//  Reset: state IDLE; timeout counter 0; all wb_* = 0; mem_err = 0; dmem_req/we/wstrb = 0; mem_stall = 0 while rst.
//  FSM IDLE/BUS/DONE. Op, address and data are latched on the IDLE->BUS edge.
//  - IDLE, ex_valid, no mem op: mem_stall=0; next edge wb_* <= ex_* with wb_data=ex_alu_result.
//  - IDLE, ex_valid=0: wb_valid <= 0.
//  - IDLE, mem op: mem_stall=1; latch op; -> BUS; wb_valid <= 0.
//  - BUS: mem_stall=1 and dmem_req=1. dmem_we/addr/wdata/wstrb stay constant from the latch.
//      On dmem_ack: capture the extracted rdata -> DONE.
//      ACK_TIMEOUT cycles with no ack: drop req, load data=0 -> DONE with err flag.
//      The counter clears on BUS entry.
//  - DONE: mem_stall=0 so upstream advances this edge. Next edge: wb_valid=1, wb_rd/wb_reg_write from latch.
//      wb_data = load data for loads, latched address for stores. mem_err=err flag. Then -> IDLE.
//      The instruction presented during DONE is not accepted; it is the held one.
//  - Minimum memory-op latency: 3 cycles (IDLE, BUS with ack on its first cycle, DONE).
//  Lanes, with a = address[1:0]:
//    SB: wdata={4{rs2[7:0]}}, wstrb=1<<a.
//    SH: wdata={2{rs2[15:0]}}, wstrb=3<<{a[1],1'b0}.
//    SW: wdata=rs2, wstrb=4'hF.
//  Load extraction: byte at rdata[8a+:8], half at rdata[16*a[1]+:16].
//    Sign-extended for funct3 000/001, zero-extended for 100/101.
//  funct3 011/110/111 are treated as word access.
//  dmem_ack outside BUS is ignored.
//  rst during BUS: dmem_req is 0 the next cycle; the access is dropped with no wb_valid.
//  wb_reg_write is forced 0 on any mem_err.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//    - Condition: halfword with a[0]=1, or word with a!=0.
//    - No bus cycle: IDLE->DONE directly; mem_err=1; wb_reg_write=0; wb_data=address.
//  Undefined:
//    - Misalignment ignored: halfword uses a[1] only, word uses lane 0.
//    - The access proceeds normally.
// TESTING
//  1 Reset then ADD result 0x1234, rd=5 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, dmem_req never 1.
//  2 LB addr 0x103, ack at first BUS cycle with rdata 0x80FF_FFFF:
//    -> dmem_addr=0x100, wb_data=0xFFFF_FF80 exactly 3 cycles after accept.
//    -> LBU on the same data gives 0x0000_0080.
//  3 SH addr 0x202, rs2=0xAAAA_BEEF, ack after 4 wait cycles:
//    -> wdata=0xBEEF_BEEF, wstrb=4'b1100.
//    -> mem_stall high through BUS; wb_reg_write=0.
//  4 LW with no ack -> req drops after exactly ACK_TIMEOUT=16 BUS cycles; mem_err pulse; wb_data=0, wb_reg_write=0.
//  5 rst asserted in 2nd BUS cycle -> dmem_req=0 next cycle; all outputs at reset values; a late ack is ignored.
//  6 LW addr 0x301:
//    with MEM_MISALIGN_TRAP_EN -> no req, mem_err=1, wb_data=0x301;
//    without -> req at 0x300, normal wb.

Source files
------------

// File: rtl/mem_stage.sv
// RV32I MEM stage: byte/half/word loads and stores over a req/ack data bus, registered MEM/WB outputs.
// Build option: `define MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses without a bus cycle.
module mem_stage #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_rs2_data,
   input  logic [2:0]  ex_funct3,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic [31:0] wb_data,
   output logic        mem_err
);

   localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      DONE
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          load_q;
   logic          reg_write_q;
   logic          err_q;
   logic [4:0]    rd_q;
   logic [2:0]    funct3_q;
   logic [31:0]   addr_q;
   logic [31:0]   ldata_q;

   logic          mem_op;
   logic          misaligned;
   logic [31:0]   wdata_d;
   logic [3:0]    wstrb_d;
   logic [31:0]   ldata_d;
   logic [7:0]    rbyte;
   logic [15:0]   rhalf;

   assign mem_op = ex_mem_read | ex_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      misaligned = 1'b0;
      if (ex_funct3[1:0] == 2'b01)
         misaligned = ex_alu_result[0];
      else if (ex_funct3[1])
         misaligned = (ex_alu_result[1:0] != 2'b00);
   end
`else
   assign misaligned = 1'b0;
`endif

   // Store lane steering from the incoming instruction; latched on entry to BUS.
   always_comb begin
      wdata_d = ex_rs2_data;
      wstrb_d = 4'hF;
      case (ex_funct3[1:0])
         2'b00: begin
            wdata_d = {4{ex_rs2_data[7:0]}};
            wstrb_d = 4'b0001 << ex_alu_result[1:0];
         end
         2'b01: begin
            wdata_d = {2{ex_rs2_data[15:0]}};
            wstrb_d = ex_alu_result[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata_d = ex_rs2_data;
            wstrb_d = 4'hF;
         end
      endcase
   end

   // Load extraction uses the latched address/size, not the live EX inputs.
   always_comb begin
      ldata_d = dmem_rdata;
      rbyte   = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
      rhalf   = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (funct3_q[1:0])
         2'b00:   ldata_d = {{24{~funct3_q[2] & rbyte[7]}}, rbyte};
         2'b01:   ldata_d = {{16{~funct3_q[2] & rhalf[15]}}, rhalf};
         default: ldata_d = dmem_rdata;
      endcase
   end

   always_comb begin
      mem_stall = 1'b0;
      if (!rst)
         mem_stall = (state_q == BUS) || ((state_q == IDLE) && ex_valid && mem_op);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         load_q       <= 1'b0;
         reg_write_q  <= 1'b0;
         err_q        <= 1'b0;
         rd_q         <= '0;
         funct3_q     <= '0;
         addr_q       <= '0;
         ldata_q      <= '0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         dmem_wstrb   <= '0;
         wb_valid     <= 1'b0;
         wb_rd        <= '0;
         wb_reg_write <= 1'b0;
         wb_data      <= '0;
         mem_err      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               mem_err <= 1'b0;
               if (ex_valid && mem_op) begin
                  wb_valid    <= 1'b0;
                  rd_q        <= ex_rd;
                  reg_write_q <= ex_reg_write;
                  load_q      <= ex_mem_read;
                  funct3_q    <= ex_funct3;
                  addr_q      <= ex_alu_result;
                  cnt_q       <= '0;
                  if (misaligned) begin
                     // Trapped access reports its address through the load-data path.
                     err_q   <= 1'b1;
                     ldata_q <= ex_alu_result;
                     state_q <= DONE;
                  end else begin
                     err_q      <= 1'b0;
                     dmem_req   <= 1'b1;
                     dmem_we    <= ex_mem_write;
                     dmem_addr  <= {ex_alu_result[31:2], 2'b00};
                     dmem_wdata <= wdata_d;
                     dmem_wstrb <= ex_mem_write ? wstrb_d : 4'h0;
                     state_q    <= BUS;
                  end
               end else begin
                  wb_valid <= ex_valid;
                  if (ex_valid) begin
                     wb_rd        <= ex_rd;
                     wb_reg_write <= ex_reg_write;
                     wb_data      <= ex_alu_result;
                  end
               end
            end
            BUS: begin
               if (dmem_ack) begin
                  ldata_q  <= ldata_d;
                  dmem_req <= 1'b0;
                  state_q  <= DONE;
               end else if (cnt_q == CNT_LAST) begin
                  ldata_q  <= '0;
                  err_q    <= 1'b1;
                  dmem_req <= 1'b0;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               wb_valid     <= 1'b1;
               wb_rd        <= rd_q;
               wb_reg_write <= reg_write_q & ~err_q;
               wb_data      <= load_q ? ldata_q : addr_q;
               mem_err      <= err_q;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a scoreboard queue holds expected MEM/WB results, popped when wb_valid fires.
module tb_mem_stage;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_rs2_data;
   logic [2:0]  ex_funct3;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        mem_stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic [31:0] wb_data;
   logic        mem_err;

   mem_stage #(.ACK_TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (ex_valid),
      .ex_alu_result (ex_alu_result),
      .ex_rs2_data   (ex_rs2_data),
      .ex_funct3     (ex_funct3),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .mem_stall     (mem_stall),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_wstrb    (dmem_wstrb),
      .dmem_ack      (dmem_ack),
      .dmem_rdata    (dmem_rdata),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_data       (wb_data),
      .mem_err       (mem_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic [4:0]  rd;
      logic        rw;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: timing, rd, write enable, data and error of every writeback.
   always @(negedge clk) begin
      if (wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("wb_unexpected", {31'b0, wb_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_cycle", cyc, e.cyc);
            chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
            chk("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, e.rw});
            chk("wb_data", wb_data, e.data);
            chk("mem_err", {31'b0, mem_err}, {31'b0, e.err});
         end
      end else if (!rst) begin
         chk("mem_err_without_wb", {31'b0, mem_err}, 32'd0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd, input logic rw);
      ex_valid      = v;
      ex_mem_read   = rd_en;
      ex_mem_write  = wr_en;
      ex_funct3     = f3;
      ex_alu_result = alu;
      ex_rs2_data   = rs2;
      ex_rd         = rd;
      ex_reg_write  = rw;
   endtask

   task automatic idle_ex();
      ex_valid     = 1'b0;
      ex_mem_read  = 1'b0;
      ex_mem_write = 1'b0;
   endtask

   // One memory access: ack in BUS cycle 'waits' (0-based) or never when ack_en=0.
   task automatic access(input string tag, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd, input logic rw,
                         input int unsigned waits, input logic ack_en, input logic [31:0] rdata,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                         input logic [31:0] exp_data, input logic exp_err);
      exp_t e;
      int unsigned nbus;
      nbus = ack_en ? waits + 1 : TO;
      drive(1'b1, rd_en, wr_en, f3, addr, rs2, rd, rw);
      e.cyc  = cyc + nbus + 2;
      e.rd   = rd;
      e.rw   = rw & ~exp_err;
      e.data = exp_data;
      e.err  = exp_err;
      sb.push_back(e);
      #1;
      chk({tag, "_stall_idle"}, {31'b0, mem_stall}, 32'd1);
      for (int unsigned i = 0; i < nbus; i++) begin
         tick();
         chk({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
         chk({tag, "_stall_bus"}, {31'b0, mem_stall}, 32'd1);
         chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
         chk({tag, "_we"}, {31'b0, dmem_we}, {31'b0, wr_en});
         chk({tag, "_wstrb"}, {28'b0, dmem_wstrb}, {28'b0, exp_wstrb});
         if (wr_en) chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
         if (ack_en && i == waits) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
         end else begin
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
         end
      end
      tick();
      dmem_ack = 1'b0;
      chk({tag, "_req_dropped"}, {31'b0, dmem_req}, 32'd0);
      chk({tag, "_stall_done"}, {31'b0, mem_stall}, 32'd0);
      tick();
      idle_ex();
   endtask

   initial begin
      rst        = 1'b1;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd3, 1'b1);
      tick();
      chk("stall_in_reset", {31'b0, mem_stall}, 32'd0);
      tick();
      tick();
      chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
      chk("rst_wb_reg_write", {31'b0, wb_reg_write}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_mem_err", {31'b0, mem_err}, 32'd0);
      chk("rst_req", {31'b0, dmem_req}, 32'd0);
      chk("rst_we", {31'b0, dmem_we}, 32'd0);
      chk("rst_wstrb", {28'b0, dmem_wstrb}, 32'd0);
      rst = 1'b0;
      idle_ex();
      tick();

      // ADD passes straight through in one cycle.
      begin
         exp_t e;
         drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
         e.cyc = cyc + 1; e.rd = 5'd5; e.rw = 1'b1; e.data = 32'h1234; e.err = 1'b0;
         sb.push_back(e);
         #1;
         chk("add_stall", {31'b0, mem_stall}, 32'd0);
         tick();
         idle_ex();
         chk("add_no_req", {31'b0, dmem_req}, 32'd0);
         tick();
         chk("add_no_req2", {31'b0, dmem_req}, 32'd0);
      end

      // Stray ack in IDLE must be ignored.
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("stray_ack_req", {31'b0, dmem_req}, 32'd0);
      tick();

      access("lb",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6,  1'b1, 0, 1'b1, 32'h80FF_FFFF, 32'h0, 4'h0, 32'hFFFF_FF80, 1'b0);
      access("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd7,  1'b1, 0, 1'b1, 32'h80FF_FFFF, 32'h0, 4'h0, 32'h0000_0080, 1'b0);
      access("lh",  1'b1, 1'b0, 3'b001, 32'h106, 32'h0, 5'd8,  1'b1, 1, 1'b1, 32'h8001_7FFF, 32'h0, 4'h0, 32'hFFFF_8001, 1'b0);
      access("lhu", 1'b1, 1'b0, 3'b101, 32'h106, 32'h0, 5'd10, 1'b1, 0, 1'b1, 32'h8001_7FFF, 32'h0, 4'h0, 32'h0000_8001, 1'b0);
      access("lh_lo", 1'b1, 1'b0, 3'b001, 32'h104, 32'h0, 5'd11, 1'b1, 0, 1'b1, 32'h8001_7FFF, 32'h0, 4'h0, 32'h0000_7FFF, 1'b0);
      access("lw_f110", 1'b1, 1'b0, 3'b110, 32'h108, 32'h0, 5'd12, 1'b1, 0, 1'b1, 32'hDEAD_BEEF, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
      access("sh",  1'b0, 1'b1, 3'b001, 32'h202, 32'hAAAA_BEEF, 5'd0, 1'b0, 4, 1'b1, 32'h0, 32'hBEEF_BEEF, 4'b1100, 32'h202, 1'b0);
      access("sb",  1'b0, 1'b1, 3'b000, 32'h201, 32'h1234_56A5, 5'd0, 1'b0, 0, 1'b1, 32'h0, 32'hA5A5_A5A5, 4'b0010, 32'h201, 1'b0);
      access("sw",  1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 5'd0, 1'b0, 2, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h300, 1'b0);
      access("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd9, 1'b1, 0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1);

      // Reset in the second BUS cycle drops the access.
      drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd13, 1'b1);
      tick();
      chk("rstbus_req1", {31'b0, dmem_req}, 32'd1);
      tick();
      rst = 1'b1;
      idle_ex();
      #1;
      chk("rstbus_stall", {31'b0, mem_stall}, 32'd0);
      tick();
      chk("rstbus_req_low", {31'b0, dmem_req}, 32'd0);
      chk("rstbus_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("rstbus_wb_data", wb_data, 32'd0);
      chk("rstbus_wb_rd", {27'b0, wb_rd}, 32'd0);
      chk("rstbus_wstrb", {28'b0, dmem_wstrb}, 32'd0);
      rst      = 1'b0;
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
      chk("late_ack_wb", {31'b0, wb_valid}, 32'd0);
      tick();

`ifdef MEM_MISALIGN_TRAP_EN
      begin
         exp_t e;
         drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h301, 32'h0, 5'd14, 1'b1);
         e.cyc = cyc + 2; e.rd = 5'd14; e.rw = 1'b0; e.data = 32'h301; e.err = 1'b1;
         sb.push_back(e);
         #1;
         chk("mis_stall_idle", {31'b0, mem_stall}, 32'd1);
         tick();
         chk("mis_no_req", {31'b0, dmem_req}, 32'd0);
         chk("mis_stall_done", {31'b0, mem_stall}, 32'd0);
         tick();
         idle_ex();
      end
`else
      access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h301, 32'h0, 5'd14, 1'b1, 1, 1'b1, 32'h1122_3344, 32'h0, 4'h0, 32'h1122_3344, 1'b0);
`endif

      tick();
      tick();
      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
